// File: rtl/dict_hamming_decompressor.sv
// Dictionary decompressor: expands NUM_CHUNKS codebook indices into a serial MSB-first bit stream.
// Define DICT_HAMMING_CODEBOOK_LOAD_EN to make the codebook a writable register file.
module dict_hamming_decompressor #(
  parameter int unsigned CHUNK_SIZE    = 4,
  parameter int unsigned CODEBOOK_SIZE = 8,
  parameter int unsigned NUM_CHUNKS    = 4,
  localparam int unsigned INDEX_BITS   = $clog2(CODEBOOK_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHUNKS*INDEX_BITS-1:0] compressed_in,
  input  logic                             load,
  output logic                             load_ready,
  output logic                             data_out,
  output logic                             data_valid,
  input  logic                             data_ready,
  output logic                             data_last,
  output logic                             decompression_done
`ifdef DICT_HAMMING_CODEBOOK_LOAD_EN
  ,
  input  logic                             cb_wr_en,
  input  logic [INDEX_BITS-1:0]            cb_wr_addr,
  input  logic [CHUNK_SIZE-1:0]            cb_wr_data
`endif
);

  localparam int unsigned TotalBits = NUM_CHUNKS * CHUNK_SIZE;
  localparam int unsigned CntBits   = $clog2(TotalBits);
  localparam int unsigned WordBits  = NUM_CHUNKS * INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  // Thermometer-style ring: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, ...
  function automatic logic [CHUNK_SIZE-1:0] default_entry(input int unsigned idx);
    int unsigned j;
    logic [CHUNK_SIZE-1:0] e;
    j = idx % (2 * CHUNK_SIZE);
    for (int unsigned b = 0; b < CHUNK_SIZE; b++) begin
      if (j <= CHUNK_SIZE) e[b] = (b < j);
      else                 e[b] = (b >= j - CHUNK_SIZE);
    end
    return e;
  endfunction

  logic [CHUNK_SIZE-1:0] cb [CODEBOOK_SIZE];

`ifdef DICT_HAMMING_CODEBOOK_LOAD_EN
  logic [CHUNK_SIZE-1:0] cb_q [CODEBOOK_SIZE];
  logic [CHUNK_SIZE-1:0] cb_d [CODEBOOK_SIZE];

  always_comb begin
    cb_d = cb_q;
    if (cb_wr_en) begin
      for (int unsigned e = 0; e < CODEBOOK_SIZE; e++) begin
        if (cb_wr_addr == INDEX_BITS'(e)) cb_d[e] = cb_wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < CODEBOOK_SIZE; e++) cb_q[e] <= default_entry(e);
    end else begin
      cb_q <= cb_d;
    end
  end

  always_comb cb = cb_q;
`else
  for (genvar g = 0; g < CODEBOOK_SIZE; g++) begin : g_const_cb
    assign cb[g] = default_entry(g);
  end
`endif

  state_e                state_q, state_d;
  logic [CntBits-1:0]    cnt_q, cnt_d;
  logic [WordBits-1:0]   word_q, word_d;
  logic [CHUNK_SIZE-1:0] chunk_q, chunk_d;

  logic                  accept;
  logic [CntBits-1:0]    cnt_inc;
  logic [CntBits-1:0]    pos;
  logic [CntBits-1:0]    nxt_chunk;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [CHUNK_SIZE-1:0] lk_entry;
  logic                  cur_bit;

  always_comb begin
    load_ready         = (state_q != StEmit);
    data_valid         = (state_q == StEmit);
    decompression_done = (state_q == StDone);
    data_last          = data_valid && (cnt_q == CntBits'(TotalBits - 1));
    accept             = load && load_ready;

    cnt_inc   = cnt_q + 1'b1;
    pos       = CntBits'(cnt_q % CHUNK_SIZE);
    nxt_chunk = CntBits'(cnt_inc / CHUNK_SIZE);

    cur_bit = 1'b0;
    for (int unsigned b = 0; b < CHUNK_SIZE; b++) begin
      if (pos == CntBits'(b)) cur_bit = chunk_q[CHUNK_SIZE-1-b];
    end
    data_out = data_valid && cur_bit;

    // One shared lookup: chunk 0 of an incoming word, or the next chunk of the latched word.
    lk_idx = compressed_in[INDEX_BITS-1:0];
    if (state_q == StEmit) begin
      lk_idx = '0;
      for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
        if (nxt_chunk == CntBits'(c)) lk_idx = word_q[c*INDEX_BITS +: INDEX_BITS];
      end
    end
    lk_entry = '0;
    for (int unsigned e = 0; e < CODEBOOK_SIZE; e++) begin
      if (lk_idx == INDEX_BITS'(e)) lk_entry = cb[e];
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    chunk_d = chunk_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = StEmit;
          word_d  = compressed_in;
          cnt_d   = '0;
          chunk_d = lk_entry;
        end
      end
      StEmit: begin
        if (data_ready) begin
          if (cnt_q == CntBits'(TotalBits - 1)) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (pos == CntBits'(CHUNK_SIZE - 1)) chunk_d = lk_entry;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      chunk_q <= chunk_d;
    end
  end

endmodule

// File: tb/tb_dict_hamming_decompressor.sv
// Directed bench for dict_hamming_decompressor with hand-computed bit streams.
module tb_dict_hamming_decompressor;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] compressed_in;
  logic        load;
  logic        load_ready;
  logic        data_out;
  logic        data_valid;
  logic        data_ready;
  logic        data_last;
  logic        decompression_done;
`ifdef DICT_HAMMING_CODEBOOK_LOAD_EN
  logic        cb_wr_en;
  logic [2:0]  cb_wr_addr;
  logic [3:0]  cb_wr_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dict_hamming_decompressor dut (
    .clk                (clk),
    .rst                (rst),
    .compressed_in      (compressed_in),
    .load               (load),
    .load_ready         (load_ready),
    .data_out           (data_out),
    .data_valid         (data_valid),
    .data_ready         (data_ready),
    .data_last          (data_last),
    .decompression_done (decompression_done)
`ifdef DICT_HAMMING_CODEBOOK_LOAD_EN
    ,
    .cb_wr_en           (cb_wr_en),
    .cb_wr_addr         (cb_wr_addr),
    .cb_wr_data         (cb_wr_data)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {data_valid, data_last, data_out, load_ready} while bit k of exp is on the wire.
  task automatic check_bit(input string tag, input int k, input logic [15:0] exp);
    logic [3:0] want;
    want = {1'b1, (k == 15), exp[15-k], 1'b0};
    check(tag, {data_valid, data_last, data_out, load_ready}, want);
  endtask

  // {decompression_done, data_valid, load_ready, data_out}
  task automatic check_done(input string tag);
    check(tag, {decompression_done, data_valid, load_ready, data_out}, 4'b1010);
  endtask

  task automatic check_idle(input string tag);
    check(tag, {decompression_done, data_valid, load_ready, data_out, data_last}, 5'b00100);
  endtask

  task automatic run_word(input logic [11:0] w, input logic [15:0] exp, input int stall_at,
                          input int stall_n, input bit spam);
    load = 1'b1;
    compressed_in = w;
    data_ready = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (spam) begin
        load = (k < 12);
        compressed_in = 12'hFFF;
      end
      if (k == stall_at) begin
        data_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check_bit("stall_hold", k, exp);
        end
        data_ready = 1'b1;
      end
      check_bit("bit", k, exp);
      tick();
    end
    check_done("done");
    tick();
    check_idle("idle_after");
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    data_ready = 1'b0;
    compressed_in = '0;
`ifdef DICT_HAMMING_CODEBOOK_LOAD_EN
    cb_wr_en = 1'b0;
    cb_wr_addr = '0;
    cb_wr_data = '0;
`endif
    #1;
    check_idle("reset_state");
    tick();
    tick();
    rst = 1'b0;
    check_idle("post_reset");

    // 3A0: idx 0,4,6,1 -> 0000 1111 1100 0001
    run_word(12'h3A0, 16'h0FC1, -1, 0, 1'b0);
    // Stall three cycles on bit 5 (value 1)
    run_word(12'h3A0, 16'h0FC1, 5, 3, 1'b0);
    // Loads while emitting must be ignored
    run_word(12'h3A0, 16'h0FC1, -1, 0, 1'b1);

    // Reset in the middle of a word
    load = 1'b1;
    compressed_in = 12'h3A0;
    data_ready = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check_bit("pre_rst_bit8", 8, 16'h0FC1);
    rst = 1'b1;
    #1;
    check_idle("rst_immediate");
    tick();
    rst = 1'b0;
    check_idle("rst_released");
    tick();
    check_idle("rst_no_done");
    run_word(12'h000, 16'h0000, -1, 0, 1'b0);

    // Back-to-back with load held: 924 has idx 4,4,4,4 -> all ones
    load = 1'b1;
    compressed_in = 12'h3A0;
    data_ready = 1'b1;
    tick();
    compressed_in = 12'h924;
    for (int k = 0; k < 16; k++) begin
      check_bit("b2b_first", k, 16'h0FC1);
      tick();
    end
    check_done("b2b_done1");
    tick();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_bit("b2b_second", k, 16'hFFFF);
      tick();
    end
    check_done("b2b_done2");
    tick();
    check_idle("b2b_idle");

`ifdef DICT_HAMMING_CODEBOOK_LOAD_EN
    cb_wr_en = 1'b1;
    cb_wr_addr = 3'd0;
    cb_wr_data = 4'b1010;
    tick();
    cb_wr_en = 1'b0;
    run_word(12'h000, 16'hAAAA, -1, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_word(12'h000, 16'h0000, -1, 0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
